// File: rtl/mem_arbiter.sv
// mem_arbiter
// Two-requester, round-robin access controller for a 4-byte store.
// Sequences single-byte read/write transactions from requesters A and B
// onto one data/store/addr memory port. The store strobe and the done
// pulses are registered, so they are glitch-free.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_a/req_b           request, held high until the matching done pulse
//   we_a/we_b             1 = write, 0 = read (sampled with the request)
//   addr_a/addr_b [1:0]   byte address
//   wdata_a/wdata_b [7:0] write data
//   done_a/done_b         one-cycle completion pulse to the owner
//   rdata [7:0]           read result, held until the next read completes
//   busy                  high whenever the FSM is not idle
//   owner                 0 = A, 1 = B; current or last granted requester
//   mem_data/mem_addr     data/address to the memory
//   mem_store             registered write strobe to the memory
//   mem_q [7:0]           byte read back from the memory
module mem_arbiter #(
  parameter int STORE_CYCLES = 1  // strobe width in cycles, 1..4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       we_a,
  input  logic       we_b,
  input  logic [1:0] addr_a,
  input  logic [1:0] addr_b,
  input  logic [7:0] wdata_a,
  input  logic [7:0] wdata_b,
  output logic       done_a,
  output logic       done_b,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       owner,
  output logic [7:0] mem_data,
  output logic       mem_store,
  output logic [1:0] mem_addr,
  input  logic [7:0] mem_q
);

  typedef enum logic [2:0] {IDLE, SETUP, STORE, HOLD, DONE} state_t;

  // Counter reload value: the counter runs STORE_LOAD..0 while in STORE.
  localparam logic [1:0] STORE_LOAD = 2'(STORE_CYCLES - 1);

  state_t     state_reg, state_next;
  logic       owner_reg;
  logic       we_reg;
  logic       last_reg;      // last-served requester (0 = A, 1 = B)
  logic [1:0] addr_reg;
  logic [1:0] cnt_reg;
  logic [7:0] wdata_reg;
  logic [7:0] rdata_reg;
  logic       store_reg;
  logic       done_a_reg;
  logic       done_b_reg;
  logic       grant;         // requester that would win in IDLE

  // On a tie the requester not served last wins; otherwise the sole requester.
  always_comb begin
    grant = 1'b0;
    if (req_a && req_b) grant = ~last_reg;
    else                grant = ~req_a;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_a || req_b) state_next = SETUP;
      SETUP:   state_next = we_reg ? STORE : DONE;
      STORE:   if (cnt_reg == 2'd0) state_next = HOLD;
      HOLD:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      owner_reg  <= 1'b0;
      we_reg     <= 1'b0;
      last_reg   <= 1'b1;
      addr_reg   <= 2'd0;
      cnt_reg    <= 2'd0;
      wdata_reg  <= 8'd0;
      rdata_reg  <= 8'd0;
      store_reg  <= 1'b0;
      done_a_reg <= 1'b0;
      done_b_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // Outputs are decoded from the next state so they line up with it
      // while still coming straight out of flops.
      store_reg  <= (state_next == STORE);
      done_a_reg <= (state_next == DONE) && !owner_reg;
      done_b_reg <= (state_next == DONE) &&  owner_reg;

      if (state_reg == IDLE && state_next == SETUP) begin
        owner_reg <= grant;
        we_reg    <= grant ? we_b    : we_a;
        addr_reg  <= grant ? addr_b  : addr_a;
        wdata_reg <= grant ? wdata_b : wdata_a;
      end

      if (state_reg == SETUP && we_reg)
        cnt_reg <= STORE_LOAD;
      else if (state_reg == STORE && cnt_reg != 2'd0)
        cnt_reg <= cnt_reg - 2'd1;

      // Address has been stable on the memory for the whole SETUP cycle.
      if (state_reg == SETUP && !we_reg)
        rdata_reg <= mem_q;

      if (state_reg == DONE)
        last_reg <= owner_reg;
    end
  end

  // Latched transaction registers only change at grant, so the memory
  // port keeps its last values while idle.
  assign mem_addr  = addr_reg;
  assign mem_data  = wdata_reg;
  assign mem_store = store_reg;
  assign done_a    = done_a_reg;
  assign done_b    = done_b_reg;
  assign rdata     = rdata_reg;
  assign owner     = owner_reg;
  assign busy      = (state_reg != IDLE);

endmodule
